cpu_stage_sequencer: RTL and testbench
======================================

Name: cpu_stage_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Generates the `stage` value consumed by the register-file write-back control, ALU, memory interface and PC logic.
- Sequences fetch, decode, execute, optional memory access, register update and PC update.
- Handles the memory ready handshake with a timeout, halts on illegal/SYSTEM opcodes, and keeps cycle and retired-instruction counters.

Parameters:
- COUNTER_WIDTH, 32: width of the cycle and instret counters.
- MEM_TIMEOUT, 255: maximum wait cycles for mem_ready in FETCH or MEMORY; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  input  1  memory completes the current access this cycle.
- stage  output  `STAGE_WIDTH  current stage encoding.
- mem_request  output  1  memory access requested; high in FETCH/MEMORY.
- instr_load  output  1  latch the fetched word into the instruction register.
- pc_write  output  1  commit next PC.
- halted  output  1  core stopped; leave only via reset.
- illegal_instruction  output  1  sticky: halt caused by an unknown opcode.
- bus_error  output  1  sticky: halt caused by memory timeout.
- cycle_count  output  COUNTER_WIDTH  cycles executed since reset.
- instret  output  COUNTER_WIDTH  instructions retired since reset.

Behaviour:
- Reset (reset_n low at a clock edge):
  - Next state is FETCH; counters, wait counter and sticky flags clear.
  - While reset_n is low, mem_request, instr_load and pc_write are forced to 0.
  - First cycle after reset: stage=FETCH, mem_request=1, every other output 0.
- Stage encodings (3 bits): FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, REGISTER_UPDATE=4, PC_UPDATE=5, HALTED=7. Encoding 6 is unused and maps to HALTED.
- FETCH:
  - mem_request=1.
  - If mem_ready=1: instr_load=1 (combinational, same cycle) and next state is DECODE.
  - Otherwise stay in FETCH.
- DECODE, one cycle; next state depends on opcode:
  - Legal opcodes (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, MISC_MEM 0001111): go to EXECUTE.
  - SYSTEM 1110011: go to HALTED, illegal_instruction stays 0.
  - Any other opcode: go to HALTED and set illegal_instruction=1.
- EXECUTE, one cycle: LOAD/STORE go to MEMORY; all others go to REGISTER_UPDATE.
- MEMORY: mem_request=1; mem_ready=1 goes to REGISTER_UPDATE, otherwise hold.
- REGISTER_UPDATE: one cycle, then PC_UPDATE. Write enable is gated downstream by opcode.
- PC_UPDATE: pc_write=1 for exactly one cycle; instret increments (wraps); next state FETCH.
- HALTED: absorbing state.
  - halted=1; mem_request, instr_load and pc_write are 0.
  - mem_ready is ignored.
- mem_ready in any stage other than FETCH/MEMORY is ignored.
- Memory timeout (MEM_TIMEOUT > 0):
  - The wait counter clears on entry to FETCH or MEMORY and increments each cycle there with mem_ready=0.
  - When the counter equals MEM_TIMEOUT and mem_ready=0: next state HALTED, bus_error=1.
  - mem_ready=1 on that same cycle wins: normal transition, no error.
- cycle_count increments on every non-reset cycle while not HALTED, and wraps.
- Counter and flag outputs are registered; instr_load, pc_write and mem_request are combinational from state plus mem_ready.

Decomposition:
- Stage encodings, `STAGE_WIDTH ([2:0]) and RISCV opcode constants live in the shared arch_defines include. Reuse them; no local literals.
- Optional sub-module mem_wait_timer holds the wait counter and compare, parameterized by MEM_TIMEOUT, with outputs `expired`.
- Everything else stays in one module.

Test Plan:
- ADD:
  - Stimulus: reset, opcode=0110011, mem_ready high in the 2nd FETCH cycle.
  - Required: stage sequence 0,0,1,2,4,5,0; instr_load single pulse in 2nd cycle; pc_write single pulse; instret=1; cycle_count=6 on return to FETCH.
- LOAD:
  - Stimulus: opcode 0000011, mem_ready asserted on the 3rd MEMORY cycle.
  - Required: stage 3 held exactly 3 cycles, mem_request=1 throughout, then 4, 5; instret increments once.
- Illegal opcode:
  - Stimulus: opcode 0000000.
  - Required: after DECODE, stage=7, halted=1, illegal_instruction=1, no pc_write, cycle_count frozen; further mem_ready pulses have no effect.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ready held 0 in FETCH.
  - Required: HALTED after 5 FETCH cycles (counter 0..4), bus_error=1.
  - Repeat with mem_ready=1 on the 5th cycle: DECODE follows, bus_error=0.
- Reset mid-operation:
  - Stimulus: reset_n low for one edge while stage=MEMORY with instret=3.
  - Required: next cycle stage=0, instret=0, cycle_count=0, flags 0.
- SYSTEM opcode:
  - Stimulus: opcode 1110011.
  - Required: HALTED with illegal_instruction=0, bus_error=0.

Source files
------------

// File: rtl/cpu_stage_sequencer_pkg.sv
// Stage enum and opcode classification helpers for the stage sequencer.
`include "arch_defines.svh"

package cpu_stage_sequencer_pkg;

    typedef enum logic [`STAGE_WIDTH-1:0] {
        ST_FETCH    = `STAGE_FETCH,
        ST_DECODE   = `STAGE_DECODE,
        ST_EXECUTE  = `STAGE_EXECUTE,
        ST_MEMORY   = `STAGE_MEMORY,
        ST_REG_UPD  = `STAGE_REGISTER_UPDATE,
        ST_PC_UPD   = `STAGE_PC_UPDATE,
        ST_HALTED   = `STAGE_HALTED
    } stage_e;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            `RISCV_LUI, `RISCV_AUIPC, `RISCV_JAL, `RISCV_JALR, `RISCV_BRANCH,
            `RISCV_LOAD, `RISCV_STORE, `RISCV_OP_IMM, `RISCV_OP,
            `RISCV_MISC_MEM: legal = 1'b1;
            default:         legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic is_mem_opcode(input logic [6:0] op);
        return (op == `RISCV_LOAD) || (op == `RISCV_STORE);
    endfunction

endpackage

// File: rtl/arch_defines.svh
// Shared RV32I architectural constants: stage encodings and base opcodes.
`ifndef ARCH_DEFINES_SVH
`define ARCH_DEFINES_SVH

`define STAGE_WIDTH            3
`define STAGE_FETCH            3'd0
`define STAGE_DECODE           3'd1
`define STAGE_EXECUTE          3'd2
`define STAGE_MEMORY           3'd3
`define STAGE_REGISTER_UPDATE  3'd4
`define STAGE_PC_UPDATE        3'd5
`define STAGE_HALTED           3'd7

`define RISCV_LUI              7'b0110111
`define RISCV_AUIPC            7'b0010111
`define RISCV_JAL              7'b1101111
`define RISCV_JALR             7'b1100111
`define RISCV_BRANCH           7'b1100011
`define RISCV_LOAD             7'b0000011
`define RISCV_STORE            7'b0100011
`define RISCV_OP_IMM           7'b0010011
`define RISCV_OP               7'b0110011
`define RISCV_MISC_MEM         7'b0001111
`define RISCV_SYSTEM           7'b1110011

`endif

// File: rtl/mem_wait_timer.sv
// Counts wait cycles spent in a memory-handshake stage; flags when the limit is reached.
// Latency: expired is registered-count compare; a restart clears the count next cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic tick,
    output logic expired
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            assign expired = (cnt_q == LIMIT);
        end else begin : g_no_timeout
            assign expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/reg-update/pc-update with halt.
// Strobes are combinational from state and mem_ready; counters and sticky flags are registered.
`include "arch_defines.svh"

module cpu_stage_sequencer
    import cpu_stage_sequencer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [6:0]               opcode,
    input  logic                     mem_ready,
    output logic [`STAGE_WIDTH-1:0]  stage,
    output logic                     mem_request,
    output logic                     instr_load,
    output logic                     pc_write,
    output logic                     halted,
    output logic                     illegal_instruction,
    output logic                     bus_error,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] instret
);

    stage_e                   state_q, state_d;
    logic                     illegal_q, illegal_d;
    logic                     bus_err_q, bus_err_d;
    logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNTER_WIDTH-1:0] instret_q, instret_d;

    logic mem_req_c, instr_load_c, pc_write_c, halted_c;
    logic waiting;
    logic expired;

    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req_c    = 1'b0;
        instr_load_c = 1'b0;
        pc_write_c   = 1'b0;
        halted_c     = 1'b0;
        waiting      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                waiting   = 1'b1;
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    instr_load_c = 1'b1;
                    state_d      = ST_DECODE;
                end else if (expired) begin
                    state_d   = ST_HALTED;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(opcode)) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d = ST_HALTED;
                    // SYSTEM is a deliberate stop, not an illegal instruction.
                    if (opcode != `RISCV_SYSTEM) begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_EXECUTE: begin
                state_d = is_mem_opcode(opcode) ? ST_MEMORY : ST_REG_UPD;
            end
            ST_MEMORY: begin
                waiting   = 1'b1;
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    state_d = ST_REG_UPD;
                end else if (expired) begin
                    state_d   = ST_HALTED;
                    bus_err_d = 1'b1;
                end
            end
            ST_REG_UPD: begin
                state_d = ST_PC_UPD;
            end
            ST_PC_UPD: begin
                pc_write_c = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                // Covers HALTED and the unused encoding 6.
                halted_c = 1'b1;
                state_d  = ST_HALTED;
            end
        endcase

        cycle_d   = halted_c ? cycle_q : cycle_q + 1'b1;
        instret_d = (state_q == ST_PC_UPD) ? instret_q + 1'b1 : instret_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Any stage change restarts the wait count, so each FETCH/MEMORY visit starts at zero.
    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (state_d != state_q),
        .tick    (waiting && !mem_ready),
        .expired (expired)
    );

    assign stage               = state_q;
    assign mem_request         = reset_n && mem_req_c;
    assign instr_load          = reset_n && instr_load_c;
    assign pc_write            = reset_n && pc_write_c;
    assign halted              = halted_c;
    assign illegal_instruction = illegal_q;
    assign bus_error           = bus_err_q;
    assign cycle_count         = cycle_q;
    assign instret             = instret_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Directed bench for cpu_stage_sequencer with MEM_TIMEOUT=4.
`include "arch_defines.svh"

module tb_cpu_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic [2:0]  stage;
    logic        mem_request, instr_load, pc_write, halted;
    logic        illegal_instruction, bus_error;
    logic [31:0] cycle_count, instret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_stage_sequencer #(
        .COUNTER_WIDTH (32),
        .MEM_TIMEOUT   (4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .opcode              (opcode),
        .mem_ready           (mem_ready),
        .stage               (stage),
        .mem_request         (mem_request),
        .instr_load          (instr_load),
        .pc_write            (pc_write),
        .halted              (halted),
        .illegal_instruction (illegal_instruction),
        .bus_error           (bus_error),
        .cycle_count         (cycle_count),
        .instret             (instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive mem_ready, check stage and strobes mid-cycle, advance.
    task automatic cyc(input string tag, input logic mr, input logic [2:0] st,
                       input logic req, input logic il, input logic pw);
        mem_ready = mr;
        #1;
        chk({tag, ".stage"}, 32'(stage), 32'(st));
        chk({tag, ".mem_request"}, 32'(mem_request), 32'(req));
        chk({tag, ".instr_load"}, 32'(instr_load), 32'(il));
        chk({tag, ".pc_write"}, 32'(pc_write), 32'(pw));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string tag);
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk({tag, ".rst_req"}, 32'(mem_request), 32'd0);
        chk({tag, ".rst_il"},  32'(instr_load),  32'd0);
        chk({tag, ".rst_pw"},  32'(pc_write),    32'd0);
        @(posedge clk);
        #2;
        reset_n   = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk({tag, ".post_stage"},   32'(stage), 32'd0);
        chk({tag, ".post_req"},     32'(mem_request), 32'd1);
        chk({tag, ".post_halted"},  32'(halted), 32'd0);
        chk({tag, ".post_illegal"}, 32'(illegal_instruction), 32'd0);
        chk({tag, ".post_buserr"},  32'(bus_error), 32'd0);
        chk({tag, ".post_cycle"},   cycle_count, 32'd0);
        chk({tag, ".post_instret"}, instret, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        opcode    = `RISCV_OP;
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        do_reset("init");

        // ADD: fetch completes on the 2nd FETCH cycle
        opcode = `RISCV_OP;
        cyc("add.f0", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        cyc("add.f1", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("add.de", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("add.ex", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("add.ru", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
        cyc("add.pc", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
        chk("add.stage_back", 32'(stage), 32'd0);
        chk("add.instret", instret, 32'd1);
        chk("add.cycle", cycle_count, 32'd6);

        // LOAD: three MEMORY cycles, ready on the third
        opcode = `RISCV_LOAD;
        cyc("ld.f",  1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("ld.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("ld.ex", 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("ld.m0", 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc("ld.m1", 1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc("ld.m2", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        cyc("ld.ru", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
        cyc("ld.pc", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
        chk("ld.instret", instret, 32'd2);
        chk("ld.cycle", cycle_count, 32'd14);

        // one more ADD, then a STORE stopped by reset while in MEMORY
        opcode = `RISCV_OP_IMM;
        cyc("add2.f",  1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("add2.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("add2.ex", 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        cyc("add2.ru", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
        cyc("add2.pc", 1'b0, 3'd5, 1'b0, 1'b0, 1'b1);
        opcode = `RISCV_STORE;
        cyc("st.f",  1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("st.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("st.ex", 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        #1;
        chk("st.mem_stage", 32'(stage), 32'd3);
        chk("st.instret3", instret, 32'd3);
        do_reset("midrst");

        // timeout: five FETCH cycles without ready
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("to.f%0d", i), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        cyc("to.h0", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("to.halted", 32'(halted), 32'd1);
        chk("to.buserr", 32'(bus_error), 32'd1);
        chk("to.illegal", 32'(illegal_instruction), 32'd0);
        chk("to.cycle", cycle_count, 32'd5);
        cyc("to.h1", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("to.cycle_frozen", cycle_count, 32'd5);

        // ready on the 5th FETCH cycle beats the timeout
        do_reset("to2");
        opcode = `RISCV_OP;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("to2.f%0d", i), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        end
        cyc("to2.f4", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("to2.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        chk("to2.buserr", 32'(bus_error), 32'd0);
        chk("to2.halted", 32'(halted), 32'd0);

        // illegal opcode
        do_reset("ill");
        opcode = 7'b0000000;
        cyc("ill.f",  1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("ill.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("ill.h0", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("ill.halted", 32'(halted), 32'd1);
        chk("ill.illegal", 32'(illegal_instruction), 32'd1);
        chk("ill.buserr", 32'(bus_error), 32'd0);
        chk("ill.cycle", cycle_count, 32'd2);
        cyc("ill.h1", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        cyc("ill.h2", 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("ill.cycle_frozen", cycle_count, 32'd2);
        chk("ill.instret", instret, 32'd0);

        // SYSTEM halts without flagging an error
        do_reset("sys");
        opcode = `RISCV_SYSTEM;
        cyc("sys.f",  1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        cyc("sys.de", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
        cyc("sys.h",  1'b0, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("sys.halted", 32'(halted), 32'd1);
        chk("sys.illegal", 32'(illegal_instruction), 32'd0);
        chk("sys.buserr", 32'(bus_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
